// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// default operand width and the divide-by-zero quotient value.
package div_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [WIDTH_DEFAULT-1:0] DIV_ZERO_QUO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/abs_neg.sv
// Conditional two's complement: passes the value through, or negates it
// when negate is set. Used both for operand magnitudes and sign fix-up.
module abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/div_unit.sv
// Non-restoring signed divider, one quotient bit per cycle. Quotient goes
// to lo, remainder to hi, with a start/busy/done handshake.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [WIDTH:0]   rem, rem_next;
  logic [WIDTH-1:0] quo, quo_next;
  logic [WIDTH-1:0] dvs, dvs_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             neg_q, neg_q_next;
  logic             neg_r, neg_r_next;
  logic [WIDTH-1:0] lo_next, hi_next;
  logic             busy_next, done_next, div_zero_next;

  logic [WIDTH-1:0] dividend_abs, divisor_abs;
  logic [WIDTH:0]   rem_sh, rem_step;
  logic [WIDTH-1:0] rem_fix, quo_signed, rem_signed;

  abs_neg #(.WIDTH(WIDTH)) u_abs_dividend (
    .value  (dividend),
    .negate (dividend[WIDTH-1]),
    .result (dividend_abs)
  );

  abs_neg #(.WIDTH(WIDTH)) u_abs_divisor (
    .value  (divisor),
    .negate (divisor[WIDTH-1]),
    .result (divisor_abs)
  );

  // The shifted remainder keeps the sign of the old one, since |rem| < |divisor|.
  assign rem_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign rem_step = rem_sh[WIDTH] ? (rem_sh + {1'b0, dvs}) : (rem_sh - {1'b0, dvs});

  // Corrected remainder magnitude always fits in WIDTH bits.
  assign rem_fix  = rem[WIDTH-1:0] + (rem[WIDTH] ? dvs : '0);

  abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
    .value  (quo),
    .negate (neg_q),
    .result (quo_signed)
  );

  abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
    .value  (rem_fix),
    .negate (neg_r),
    .result (rem_signed)
  );

  always_comb begin
    state_next    = state;
    rem_next      = rem;
    quo_next      = quo;
    dvs_next      = dvs;
    cnt_next      = cnt;
    neg_q_next    = neg_q;
    neg_r_next    = neg_r;
    lo_next       = lo;
    hi_next       = hi;
    busy_next     = busy;
    done_next     = 1'b0;
    div_zero_next = div_zero;
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            lo_next       = WIDTH'(DIV_ZERO_QUO);
            hi_next       = dividend;
            div_zero_next = 1'b1;
            state_next    = DONE;
          end else begin
            rem_next   = '0;
            quo_next   = dividend_abs;
            dvs_next   = divisor_abs;
            neg_q_next = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_next = dividend[WIDTH-1];
            cnt_next   = CW'(WIDTH - 1);
            busy_next  = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        rem_next = rem_step;
        quo_next = {quo[WIDTH-2:0], ~rem_step[WIDTH]};
        if (cnt == '0) begin
          state_next = FIX;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      FIX: begin
        lo_next       = quo_signed;
        hi_next       = rem_signed;
        div_zero_next = 1'b0;
        state_next    = DONE;
      end
      DONE: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= IDLE;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      lo       <= '0;
      hi       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_next;
      rem      <= rem_next;
      quo      <= quo_next;
      dvs      <= dvs_next;
      cnt      <= cnt_next;
      neg_q    <= neg_q_next;
      neg_r    <= neg_r_next;
      lo       <= lo_next;
      hi       <= hi_next;
      busy     <= busy_next;
      done     <= done_next;
      div_zero <= div_zero_next;
    end
  end

endmodule
